neq_b_b_b: RTL and testbench



---
 rtl/neq_b_b_b_pkg.sv | 16 +
 rtl/neq_b_b_b_op_out_reg.sv | 24 ++
 rtl/neq_b_b_b.sv | 36 +++
 tb/tb_neq_b_b_b.sv | 135 +++++++++++++
 4 files changed

// File: rtl/neq_b_b_b_pkg.sv
// Shared operator-library types and build constants for the bool neq operator.
package neq_b_b_b_pkg;

    // One-bit boolean as carried on every bool-typed dataflow edge.
    typedef logic bool_t;

    // Output stage selection.
    localparam int unsigned OUT_REG_COMB = 0;
    localparam int unsigned OUT_REG_REG  = 1;

    // Boolean inequality; X/Z on either operand propagates through the XOR.
    function automatic bool_t bool_neq(input bool_t lhs, input bool_t rhs);
        return lhs ^ rhs;
    endfunction

endpackage

// File: rtl/neq_b_b_b_op_out_reg.sv
// One-bit output flop with synchronous active-high clear.
module neq_b_b_b_op_out_reg
    import neq_b_b_b_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  bool_t i_d,
    output bool_t o_q
);

    bool_t r_q;

    // Capture the result each cycle; reset wins over the data input.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/neq_b_b_b.sv
// Bool inequality operator (y = a != b) with optional registered output.
module neq_b_b_b
    import neq_b_b_b_pkg::*;
#(
    parameter int unsigned OUT_REG = OUT_REG_COMB
) (
    input  logic  clock,
    input  logic  reset,
    input  bool_t a,
    input  bool_t b,
    output bool_t y
);

    bool_t w_neq;

    // Combinational core: a single XOR.
    assign w_neq = bool_neq(a, b);

    // Output stage: either one flop or a straight wire.
    generate
        if (OUT_REG == OUT_REG_REG) begin : g_reg
            neq_b_b_b_op_out_reg u_out_reg (
                .clock (clock),
                .reset (reset),
                .i_d   (w_neq),
                .o_q   (y)
            );
        end else begin : g_comb
            // Clock and reset are present only for uniform port shape here.
            logic w_unused;
            assign w_unused = clock ^ reset;
            assign y        = w_neq;
        end
    endgenerate

endmodule

// File: tb/tb_neq_b_b_b.sv
// Directed bench for neq_b_b_b in both combinational and registered builds.
module tb_neq_b_b_b;

    logic clock;
    logic reset;
    logic a;
    logic b;
    logic y_comb;
    logic y_reg;

    int n_vec;
    int n_err;

    neq_b_b_b #(.OUT_REG(0)) u_dut_comb (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y_comb)
    );

    neq_b_b_b #(.OUT_REG(1)) u_dut_reg (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y_reg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("~~FAIL~~ %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply inputs mid-cycle, let them settle.
    task automatic drive(input logic ra, input logic rb, input logic rr);
        a     = ra;
        b     = rb;
        reset = rr;
        #1;
    endtask

    logic exp_prev;

    initial begin
        n_vec = 0;
        n_err = 0;

        // Scenario 1: long reset with zero operands.
        drive(1'b0, 1'b0, 1'b1);
        repeat (16) tick();
        chk("rst_comb", y_comb, 1'b0);
        chk("rst_reg",  y_reg,  1'b0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        chk("rel_comb", y_comb, 1'b0);
        chk("rel_reg",  y_reg,  1'b0);

        // Scenarios 2-4: truth table; comb follows in-cycle, reg after the edge.
        drive(1'b1, 1'b0, 1'b0);
        chk("v10_comb_now", y_comb, 1'b1);
        chk("v10_reg_hold", y_reg,  1'b0);
        tick();
        chk("v10_reg",      y_reg,  1'b1);

        drive(1'b0, 1'b1, 1'b0);
        chk("v01_comb_now", y_comb, 1'b1);
        tick();
        chk("v01_reg",      y_reg,  1'b1);

        drive(1'b1, 1'b1, 1'b0);
        chk("v11_comb_now", y_comb, 1'b0);
        chk("v11_reg_hold", y_reg,  1'b1);
        tick();
        chk("v11_reg",      y_reg,  1'b0);

        drive(1'b0, 1'b0, 1'b0);
        chk("v00_comb_now", y_comb, 1'b0);
        tick();
        chk("v00_reg",      y_reg,  1'b0);

        // Scenario 5: operands differ while reset is high.
        drive(1'b1, 1'b0, 1'b1);
        chk("rst10_comb_now", y_comb, 1'b1);
        tick();
        chk("rst10_comb", y_comb, 1'b1);
        chk("rst10_reg0", y_reg,  1'b0);
        tick();
        chk("rst10_reg1", y_reg,  1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("rel10_reg_hold", y_reg, 1'b0);
        tick();
        chk("rel10_reg",  y_reg,  1'b1);
        chk("rel10_comb", y_comb, 1'b1);

        // Scenario 6: toggle a with b=0; registered y trails a by one cycle.
        exp_prev = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(~a, 1'b0, 1'b0);
            chk($sformatf("tog%0d_reg_hold", i), y_reg, exp_prev);
            chk($sformatf("tog%0d_comb", i),     y_comb, (i % 2 == 0) ? 1'b0 : 1'b1);
            tick();
            chk($sformatf("tog%0d_reg", i),      y_reg, (i % 2 == 0) ? 1'b0 : 1'b1);
            exp_prev = (i % 2 == 0) ? 1'b0 : 1'b1;
        end

        // X on an operand propagates, no masking.
        drive(1'bx, 1'b0, 1'b0);
        chk("x_comb", y_comb, 1'bx);
        tick();
        chk("x_reg",  y_reg,  1'bx);

        // Reset clears an X held in the output flop.
        drive(1'b0, 1'b1, 1'b1);
        tick();
        chk("x_rst_reg", y_reg, 1'b0);
        chk("x_rst_comb", y_comb, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
